// File: rtl/int_ctrl_if.sv
// CPU-side interrupt interface for int_ctrl.
// master: CPU / device side that drives requests and control.
// slave : the interrupt controller.
interface int_ctrl_if #(
    parameter int N_CH  = 4,
    parameter int PRI_W = 3
);
    logic [N_CH-1:0]       irq;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH*PRI_W-1:0] ch_pri;
    logic [PRI_W-1:0]      cpu_pri;
    logic                  int_ld_vec;
    logic                  int_gate_vec;
    logic [1:0]            int_vec_mux;
    logic                  int_eoi;
    logic                  int_int;
    logic [15:0]           vec_data;
    logic                  vec_oe;
    logic [N_CH-1:0]       ack_ch;
    logic [N_CH-1:0]       in_service;

    modport master (
        output irq, ch_en, ch_pri, cpu_pri, int_ld_vec, int_gate_vec, int_vec_mux, int_eoi,
        input  int_int, vec_data, vec_oe, ack_ch, in_service
    );

    modport slave (
        input  irq, ch_en, ch_pri, cpu_pri, int_ld_vec, int_gate_vec, int_vec_mux, int_eoi,
        output int_int, vec_data, vec_oe, ack_ch, in_service
    );
endinterface

// File: rtl/int_ctrl.sv
// N-channel LC-3 interrupt controller.
// Optional feature: define INT_SYNC_EN to pass irq through a 2-flop
// synchronizer per channel (irq->int_int latency 3 cycles instead of 1).
//
// state    | meaning
// IDLE     | no interrupt pending; arbitrating eligible requests
// REQ      | int_int raised, winner channel and INTV frozen
// ACK      | CPU latched the vector; ack_ch pulse, channel now in service
module int_ctrl #(
    parameter int          N_CH     = 4,
    parameter int          PRI_W    = 3,
    parameter logic [7:0]  VEC_BASE = 8'h80
) (
    input  logic     clk,
    input  logic     rst_n,
    int_ctrl_if.slave bus
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [CH_W-1:0] win_ch_q, win_ch_d;
    logic [7:0]      intv_q, intv_d;
    logic [N_CH-1:0] ack_ch_q, ack_ch_d;
    logic [N_CH-1:0] in_service_q, in_service_d;

    logic [N_CH-1:0] irq_s;
    logic [N_CH-1:0] elig;
    logic            arb_found;
    logic [CH_W-1:0] arb_ch;
    logic [PRI_W-1:0] arb_pri;
    logic            eoi_found;
    logic [PRI_W-1:0] eoi_pri;
    logic [N_CH-1:0] eoi_mask;

`ifdef INT_SYNC_EN
    logic [N_CH-1:0] sync1_q, sync2_q;

    // two-flop synchronizer for asynchronous device requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.irq;
            sync2_q <= sync1_q;
        end
    end
    assign irq_s = sync2_q;
`else
    assign irq_s = bus.irq;
`endif

    // eligibility: enabled, above CPU priority, not already in service
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            elig[i] = irq_s[i] & bus.ch_en[i] & ~in_service_q[i]
                    & (bus.ch_pri[i*PRI_W +: PRI_W] > bus.cpu_pri);
        end
    end

    // arbitration: highest priority wins, strict '>' keeps the lowest index on ties
    always_comb begin
        arb_found = 1'b0;
        arb_ch    = '0;
        arb_pri   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (elig[i] && (!arb_found || bus.ch_pri[i*PRI_W +: PRI_W] > arb_pri)) begin
                arb_found = 1'b1;
                arb_ch    = CH_W'(i);
                arb_pri   = bus.ch_pri[i*PRI_W +: PRI_W];
            end
        end
    end

    // EOI target: highest-priority in-service channel, lowest index on ties
    always_comb begin
        eoi_found = 1'b0;
        eoi_pri   = '0;
        eoi_mask  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (in_service_q[i] && (!eoi_found || bus.ch_pri[i*PRI_W +: PRI_W] > eoi_pri)) begin
                eoi_found = 1'b1;
                eoi_pri   = bus.ch_pri[i*PRI_W +: PRI_W];
                eoi_mask  = N_CH'(1) << i;
            end
        end
    end

    // next-state logic; the ack pulse and in-service set share the REQ->ACK edge
    always_comb begin
        state_d  = state_q;
        win_ch_d = win_ch_q;
        intv_d   = intv_q;
        ack_ch_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d  = ST_REQ;
                    win_ch_d = arb_ch;
                    intv_d   = VEC_BASE + 8'(arb_ch);
                end
            end
            ST_REQ: begin
                if (bus.int_ld_vec) begin
                    state_d  = ST_ACK;
                    ack_ch_d = N_CH'(1) << win_ch_q;
                end else if (!elig[win_ch_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // EOI clear is taken from the pre-set mask so a same-cycle ACK survives
        in_service_d = (in_service_q & ~(bus.int_eoi ? eoi_mask : '0)) | ack_ch_d;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            win_ch_q     <= '0;
            intv_q       <= VEC_BASE;
            ack_ch_q     <= '0;
            in_service_q <= '0;
        end else begin
            state_q      <= state_d;
            win_ch_q     <= win_ch_d;
            intv_q       <= intv_d;
            ack_ch_q     <= ack_ch_d;
            in_service_q <= in_service_d;
        end
    end

    // vector mux: INTV or fixed exception vectors, independent of state
    always_comb begin
        case (bus.int_vec_mux)
            2'd0:    bus.vec_data = {8'h00, intv_q};
            2'd1:    bus.vec_data = 16'h0000;
            2'd2:    bus.vec_data = 16'h0001;
            default: bus.vec_data = 16'h0002;
        endcase
    end

    assign bus.int_int    = (state_q == ST_REQ);
    assign bus.vec_oe     = bus.int_gate_vec;
    assign bus.ack_ch     = ack_ch_q;
    assign bus.in_service = in_service_q;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl (N_CH=4, VEC_BASE=8'h80).
module tb_int_ctrl;
`ifdef INT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    int_ctrl_if #(.N_CH(4), .PRI_W(3)) bus ();

    int_ctrl #(.N_CH(4), .PRI_W(3), .VEC_BASE(8'h80)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_int(input string tag);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.int_int) break;
        end
        chk(tag, 32'(bus.int_int), 32'd1);
    endtask

    task automatic pulse_ld();
        bus.int_ld_vec = 1'b1;
        tick();
        bus.int_ld_vec = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
    endtask

    initial begin
        bus.irq          = '0;
        bus.ch_en        = 4'hF;
        bus.ch_pri       = {3'd3, 3'd5, 3'd5, 3'd2};
        bus.cpu_pri      = 3'd0;
        bus.int_ld_vec   = 1'b0;
        bus.int_gate_vec = 1'b0;
        bus.int_vec_mux  = 2'd0;
        bus.int_eoi      = 1'b0;

        // reset state
        #12;
        chk("rst_int",  32'(bus.int_int), 32'd0);
        chk("rst_ack",  32'(bus.ack_ch), 32'd0);
        chk("rst_isr",  32'(bus.in_service), 32'd0);
        chk("rst_vec",  32'(bus.vec_data), 32'h0080);
        rst_n = 1'b1;
        tick();

        // test 1: tie between ch1/ch2 at pri 5, ch1 wins
        bus.irq = 4'b0110;
        repeat (LAT - 1) tick();
        chk("t1_early", 32'(bus.int_int), 32'd0);
        tick();
        chk("t1_int", 32'(bus.int_int), 32'd1);
        chk("t1_vec", 32'(bus.vec_data), 32'h0081);
        // late higher-priority arrival must not preempt
        bus.ch_pri = {3'd7, 3'd5, 3'd5, 3'd2};
        bus.irq    = 4'b1110;
        repeat (LAT + 1) tick();
        chk("t1_nopre_int", 32'(bus.int_int), 32'd1);
        chk("t1_nopre_vec", 32'(bus.vec_data), 32'h0081);
        bus.ch_pri = {3'd3, 3'd5, 3'd5, 3'd2};
        bus.irq    = 4'b0110;

        // test 2: cpu_pri raised in REQ, request withdrawn
        bus.cpu_pri = 3'd5;
        tick();
        chk("t2_int", 32'(bus.int_int), 32'd0);
        chk("t2_ack", 32'(bus.ack_ch), 32'd0);
        chk("t2_isr", 32'(bus.in_service), 32'd0);
        tick();
        chk("t2_int2", 32'(bus.int_int), 32'd0);

        // test 3: ch2 at pri 6 acknowledged
        bus.ch_pri = {3'd3, 3'd6, 3'd5, 3'd2};
        bus.irq    = 4'b0100;
        wait_int("t3_int");
        chk("t3_vec", 32'(bus.vec_data), 32'h0082);
        pulse_ld();
        chk("t3_ack", 32'(bus.ack_ch), 32'h4);
        chk("t3_isr", 32'(bus.in_service), 32'h4);
        chk("t3_int_ack", 32'(bus.int_int), 32'd0);
        tick();
        chk("t3_ack_end", 32'(bus.ack_ch), 32'd0);
        repeat (4) tick();
        chk("t3_no_reint", 32'(bus.int_int), 32'd0);
        // int_ld_vec in IDLE is an exception load: ignored
        pulse_ld();
        chk("t3_ld_idle_ack", 32'(bus.ack_ch), 32'd0);
        chk("t3_ld_idle_isr", 32'(bus.in_service), 32'h4);

        // test 4: EOI priority order, tie to lowest index
        bus.irq = 4'b0000;
        pulse_eoi();
        chk("t4_eoi_ch2", 32'(bus.in_service), 32'd0);
        bus.cpu_pri = 3'd0;
        bus.ch_pri  = {3'd4, 3'd6, 3'd4, 3'd2};
        bus.irq     = 4'b1010;
        wait_int("t4_int1");
        chk("t4_vec1", 32'(bus.vec_data), 32'h0081);
        pulse_ld();
        chk("t4_ack1", 32'(bus.ack_ch), 32'h2);
        wait_int("t4_int3");
        chk("t4_vec3", 32'(bus.vec_data), 32'h0083);
        pulse_ld();
        chk("t4_ack3", 32'(bus.ack_ch), 32'h8);
        chk("t4_isr", 32'(bus.in_service), 32'hA);
        bus.irq = 4'b0000;
        pulse_eoi();
        chk("t4_eoi1", 32'(bus.in_service), 32'h8);
        // EOI and ACK in the same cycle: clear ch3, set ch1
        bus.irq = 4'b0010;
        wait_int("t4_int1b");
        bus.int_eoi = 1'b1;
        pulse_ld();
        bus.int_eoi = 1'b0;
        chk("t4_both_ack", 32'(bus.ack_ch), 32'h2);
        chk("t4_both_isr", 32'(bus.in_service), 32'h2);
        bus.irq = 4'b0000;
        pulse_eoi();
        chk("t4_eoi2", 32'(bus.in_service), 32'd0);
        pulse_eoi();
        chk("t4_eoi_noop", 32'(bus.in_service), 32'd0);

        // test 5: exception vectors and vec_oe
        bus.int_vec_mux  = 2'd1;
        bus.int_gate_vec = 1'b1;
        #1;
        chk("t5_vec1", 32'(bus.vec_data), 32'h0000);
        chk("t5_oe1", 32'(bus.vec_oe), 32'd1);
        bus.int_vec_mux  = 2'd2;
        bus.int_gate_vec = 1'b0;
        #1;
        chk("t5_vec2", 32'(bus.vec_data), 32'h0001);
        chk("t5_oe0", 32'(bus.vec_oe), 32'd0);
        bus.int_vec_mux = 2'd3;
        #1;
        chk("t5_vec3", 32'(bus.vec_data), 32'h0002);
        bus.int_vec_mux = 2'd0;

        // test 6: async reset mid-REQ with a channel in service
        bus.irq = 4'b1000;
        wait_int("t6_int3");
        pulse_ld();
        chk("t6_isr", 32'(bus.in_service), 32'h8);
        bus.irq = 4'b0001;
        wait_int("t6_int0");
        chk("t6_vec0", 32'(bus.vec_data), 32'h0080);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_int", 32'(bus.int_int), 32'd0);
        chk("t6_rst_ack", 32'(bus.ack_ch), 32'd0);
        chk("t6_rst_isr", 32'(bus.in_service), 32'd0);
        tick();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
